// File: rtl/ks_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone subtractor.
package ks_pkg;

  localparam int KS_WIDTH = 32;
  localparam int KS_SPLIT = 3;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int span(input int level);
    return 1 << level;
  endfunction

  // (hi) o (lo): hi group absorbs the lower adjacent group
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level; bits below SPAN already hold
// their final group (reaching bit 0) and pass straight through.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_g,
  output logic [WIDTH-1:0] o_p
);

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi < SPAN) begin : g_pass
      assign o_g[gi] = i_g[gi];
      assign o_p[gi] = i_p[gi];
    end else begin : g_cell
      pg_t w_hi;
      pg_t w_lo;
      pg_t w_res;
      assign w_hi    = {i_g[gi], i_p[gi]};
      assign w_lo    = {i_g[gi-SPAN], i_p[gi-SPAN]};
      assign w_res   = pg_combine(w_hi, w_lo);
      assign o_g[gi] = w_res.g;
      assign o_p[gi] = w_res.p;
    end
  end

endmodule

// File: rtl/ks_sub_pipe.sv
// 3-stage valid/ready Kogge-Stone subtractor: diff = a - b - bin, bout = borrow.
// Define KS_SUB_FLAGS_EN to add registered zero/neg/ovf outputs.
module ks_sub_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH,
  parameter int SPLIT = KS_SPLIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef KS_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int LOG_W = clog2(WIDTH);
  localparam int N3    = LOG_W - SPLIT;

  logic             r1_v, r2_v, r3_v;
  logic [WIDTH-1:0] r1_g, r1_p, r2_g, r2_p, r2_praw;
  logic             r1_cin, r2_cin;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_rdy2, w_rdy3;
  logic [WIDTH-1:0] w_s2g [SPLIT+1];
  logic [WIDTH-1:0] w_s2p [SPLIT+1];
  logic [WIDTH-1:0] w_s3g [N3+1];
  logic [WIDTH-1:0] w_s3p [N3];
  logic [WIDTH-1:0] w_carry, w_diff_next;

  assign w_rdy3   = ~r3_v | out_ready;
  assign w_rdy2   = ~r2_v | w_rdy3;
  assign in_ready = ~r1_v | w_rdy2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= 1'b0;
      r1_g   <= '0;
      r1_p   <= '0;
      r1_cin <= 1'b0;
    end else if (in_ready) begin
      r1_v <= in_valid;
      if (in_valid) begin
        r1_p   <= a ^ ~b;
        r1_g   <= a & ~b;
        r1_cin <= ~bin;
      end
    end
  end

  // Carry-in folded into bit 0 so every prefix G is a true carry-out.
  assign w_s2g[0] = {r1_g[WIDTH-1:1], r1_g[0] | (r1_p[0] & r1_cin)};
  assign w_s2p[0] = r1_p;

  genvar gi;
  for (gi = 0; gi < SPLIT; gi++) begin : g_lvl2
    ks_prefix_level #(.WIDTH(WIDTH), .SPAN(span(gi))) u_lvl (
      .i_g (w_s2g[gi]),
      .i_p (w_s2p[gi]),
      .o_g (w_s2g[gi+1]),
      .o_p (w_s2p[gi+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v    <= 1'b0;
      r2_g    <= '0;
      r2_p    <= '0;
      r2_praw <= '0;
      r2_cin  <= 1'b0;
    end else if (w_rdy2) begin
      r2_v <= r1_v;
      if (r1_v) begin
        r2_g    <= w_s2g[SPLIT];
        r2_p    <= w_s2p[SPLIT];
        r2_praw <= r1_p;
        r2_cin  <= r1_cin;
      end
    end
  end

  assign w_s3g[0] = r2_g;
  assign w_s3p[0] = r2_p;

  for (gi = SPLIT; gi < LOG_W; gi++) begin : g_lvl3
    if (gi == LOG_W - 1) begin : g_last
      logic [WIDTH-1:0] w_p_unused;
      ks_prefix_level #(.WIDTH(WIDTH), .SPAN(span(gi))) u_lvl (
        .i_g (w_s3g[gi-SPLIT]),
        .i_p (w_s3p[gi-SPLIT]),
        .o_g (w_s3g[gi-SPLIT+1]),
        .o_p (w_p_unused)
      );
    end else begin : g_mid
      ks_prefix_level #(.WIDTH(WIDTH), .SPAN(span(gi))) u_lvl (
        .i_g (w_s3g[gi-SPLIT]),
        .i_p (w_s3p[gi-SPLIT]),
        .o_g (w_s3g[gi-SPLIT+1]),
        .o_p (w_s3p[gi-SPLIT+1])
      );
    end
  end

  assign w_carry     = {w_s3g[N3][WIDTH-2:0], r2_cin};
  assign w_diff_next = r2_praw ^ w_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_v   <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_rdy3) begin
      r3_v <= r2_v;
      if (r2_v) begin
        r_diff <= w_diff_next;
        r_bout <= ~w_s3g[N3][WIDTH-1];
      end
    end
  end

  assign out_valid = r3_v;
  assign diff      = r_diff;
  assign bout      = r_bout;

`ifdef KS_SUB_FLAGS_EN
  logic r1_amsb, r2_amsb, r_zero, r_neg, r_ovf;

  // Opposite operand MSBs show up as raw p == 0 at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_amsb <= 1'b0;
      r2_amsb <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (in_ready && in_valid) r1_amsb <= a[WIDTH-1];
      if (w_rdy2 && r1_v)       r2_amsb <= r1_amsb;
      if (w_rdy3 && r2_v) begin
        r_zero <= ~|w_diff_next;
        r_neg  <= w_diff_next[WIDTH-1];
        r_ovf  <= ~r2_praw[WIDTH-1] & (w_diff_next[WIDTH-1] ^ r2_amsb);
      end
    end
  end

  assign zero = r_zero;
  assign neg  = r_neg;
  assign ovf  = r_ovf;
`endif

endmodule
